// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronizes a raw switch and accepts a level change only after DB_CYCLES stable cycles.
module debounce_fsm #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(DB_CYCLES);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
  logic s, last;
  assign s    = sync_q[SYNC_STAGES-1];
  assign last = cnt_q == CW'(DB_CYCLES - 1);
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], i_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ZERO: begin
        state_d = s ? WAIT1 : ZERO;
        cnt_d   = '0;
      end
      WAIT1: begin
        state_d = !s ? ZERO : last ? ONE : WAIT1;
        cnt_d   = (s && !last) ? cnt_q + 1'b1 : cnt_q;
      end
      ONE: begin
        state_d = s ? ONE : WAIT0;
        cnt_d   = '0;
      end
      WAIT0: begin
        state_d = s ? ONE : last ? ZERO : WAIT0;
        cnt_d   = (!s && !last) ? cnt_q + 1'b1 : cnt_q;
      end
      default: begin
        state_d = ZERO;
        cnt_d   = '0;
      end
    endcase
    // outputs are registered off the next state so they move on the accepting edge
    lvl_d  = (state_d == ONE) || (state_d == WAIT0);
    rise_d = (state_q == WAIT1) && (state_d == ONE);
    fall_d = (state_q == WAIT0) && (state_d == ZERO);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      state_q <= ZERO;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign o_lvl  = lvl_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed checks of debounce_fsm with SYNC_STAGES=2, DB_CYCLES=4 (latency 7 edges).
module tb_debounce_fsm;
  logic clk = 1'b0, rst_n = 1'b0, raw = 1'b0;
  logic o_lvl, o_rise, o_fall;
  logic det_q;
  int ncmp = 0, nerr = 0;
  int ec, nrise, nfall, ndet, both, chg_at, rise_at, fall_at;
  logic lvl_prev;
  debounce_fsm #(.SYNC_STAGES(2), .DB_CYCLES(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw),
    .o_lvl(o_lvl), .o_rise(o_rise), .o_fall(o_fall)
  );
  always #5 clk = ~clk;
  // downstream dual-edge detector model fed by o_lvl
  always_ff @(posedge clk or negedge rst_n) det_q <= !rst_n ? 1'b0 : o_lvl;
  task automatic clr();
    ec = 0; nrise = 0; nfall = 0; ndet = 0;
    chg_at = -1; rise_at = -1; fall_at = -1;
    lvl_prev = o_lvl;
  endtask
  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ec++;
      if (o_rise) begin nrise++; if (rise_at < 0) rise_at = ec; end
      if (o_fall) begin nfall++; if (fall_at < 0) fall_at = ec; end
      if (o_rise && o_fall) both++;
      if (o_lvl ^ det_q) ndet++;
      if (o_lvl !== lvl_prev && chg_at < 0) chg_at = ec;
      lvl_prev = o_lvl;
    end
  endtask
  task automatic test_reset();
    #2;
    ncmp++; if (o_lvl !== 1'b0) begin nerr++; $display("FAIL reset_lvl: got %b want 0", o_lvl); end
    ncmp++; if (o_rise !== 1'b0) begin nerr++; $display("FAIL reset_rise: got %b want 0", o_rise); end
    ncmp++; if (o_fall !== 1'b0) begin nerr++; $display("FAIL reset_fall: got %b want 0", o_fall); end
    @(posedge clk); #1;
    ncmp++; if (o_lvl !== 1'b0) begin nerr++; $display("FAIL reset_hold_lvl: got %b want 0", o_lvl); end
    rst_n = 1'b1;
    clr(); edges(10);
    ncmp++; if (chg_at !== -1) begin nerr++; $display("FAIL reset_idle: lvl changed at %0d want never", chg_at); end
  endtask
  task automatic test_clean_step();
    clr(); raw = 1'b1; edges(10);
    ncmp++; if (chg_at !== 7) begin nerr++; $display("FAIL step_lat: got %0d want 7", chg_at); end
    ncmp++; if (rise_at !== 7) begin nerr++; $display("FAIL step_rise_at: got %0d want 7", rise_at); end
    ncmp++; if (nrise !== 1) begin nerr++; $display("FAIL step_nrise: got %0d want 1", nrise); end
    ncmp++; if (nfall !== 0) begin nerr++; $display("FAIL step_nfall: got %0d want 0", nfall); end
    ncmp++; if (o_lvl !== 1'b1) begin nerr++; $display("FAIL step_lvl: got %b want 1", o_lvl); end
  endtask
  task automatic test_release();
    clr(); raw = 1'b0; edges(10);
    ncmp++; if (chg_at !== 7) begin nerr++; $display("FAIL rel_lat: got %0d want 7", chg_at); end
    ncmp++; if (fall_at !== 7) begin nerr++; $display("FAIL rel_fall_at: got %0d want 7", fall_at); end
    ncmp++; if (nfall !== 1) begin nerr++; $display("FAIL rel_nfall: got %0d want 1", nfall); end
    ncmp++; if (nrise !== 0) begin nerr++; $display("FAIL rel_nrise: got %0d want 0", nrise); end
    ncmp++; if (o_lvl !== 1'b0) begin nerr++; $display("FAIL rel_lvl: got %b want 0", o_lvl); end
  endtask
  task automatic test_bounce();
    clr(); raw = 1'b1; edges(3); raw = 1'b0; edges(2);
    ncmp++; if (nrise !== 0) begin nerr++; $display("FAIL bounce_early_rise: got %0d want 0", nrise); end
    clr(); raw = 1'b1; edges(10);
    ncmp++; if (chg_at !== 7) begin nerr++; $display("FAIL bounce_lat: got %0d want 7", chg_at); end
    ncmp++; if (nrise !== 1) begin nerr++; $display("FAIL bounce_nrise: got %0d want 1", nrise); end
    raw = 1'b0; edges(12);
  endtask
  task automatic test_short_pulse();
    clr(); raw = 1'b1; edges(3); raw = 1'b0; edges(10);
    ncmp++; if (chg_at !== -1) begin nerr++; $display("FAIL short_lvl: changed at %0d want never", chg_at); end
    ncmp++; if (nrise + nfall !== 0) begin nerr++; $display("FAIL short_pulses: got %0d want 0", nrise + nfall); end
  endtask
  task automatic test_boundary();
    clr(); raw = 1'b1; edges(4); raw = 1'b0; edges(10);
    ncmp++; if (nrise !== 0) begin nerr++; $display("FAIL bnd4_nrise: got %0d want 0", nrise); end
    clr(); raw = 1'b1; edges(5); raw = 1'b0; edges(10);
    ncmp++; if (rise_at !== 7) begin nerr++; $display("FAIL bnd5_rise_at: got %0d want 7", rise_at); end
    ncmp++; if (fall_at !== 12) begin nerr++; $display("FAIL bnd5_fall_at: got %0d want 12", fall_at); end
    ncmp++; if (nrise + nfall !== 2) begin nerr++; $display("FAIL bnd5_pulses: got %0d want 2", nrise + nfall); end
  endtask
  task automatic test_async_reset();
    raw = 1'b1; edges(4);
    #2 rst_n = 1'b0; raw = 1'b0; #1;
    ncmp++; if ({o_lvl, o_rise, o_fall} !== 3'b000) begin nerr++; $display("FAIL arst_wait1_out: got %b want 000", {o_lvl, o_rise, o_fall}); end
    edges(2); rst_n = 1'b1;
    clr(); edges(12);
    ncmp++; if (chg_at !== -1 || nrise !== 0) begin nerr++; $display("FAIL arst_wait1_idle: chg %0d rise %0d want -1 0", chg_at, nrise); end
    raw = 1'b1; edges(10); raw = 1'b0; edges(4);
    ncmp++; if (o_lvl !== 1'b1) begin nerr++; $display("FAIL arst_pre_wait0: got %b want 1", o_lvl); end
    #2 rst_n = 1'b0; #1;
    ncmp++; if (o_lvl !== 1'b0) begin nerr++; $display("FAIL arst_wait0_lvl: got %b want 0", o_lvl); end
    edges(2); rst_n = 1'b1;
    clr(); edges(12);
    ncmp++; if (nfall + nrise !== 0 || o_lvl !== 1'b0) begin nerr++; $display("FAIL arst_wait0_idle: pulses %0d lvl %b want 0 0", nfall + nrise, o_lvl); end
  endtask
  task automatic test_reset_raw_high();
    rst_n = 1'b0; raw = 1'b1; edges(2);
    rst_n = 1'b1;
    clr(); edges(10);
    ncmp++; if (chg_at !== 7) begin nerr++; $display("FAIL rhigh_lat: got %0d want 7", chg_at); end
    ncmp++; if (nrise !== 1) begin nerr++; $display("FAIL rhigh_nrise: got %0d want 1", nrise); end
  endtask
  task automatic test_chain();
    logic [5:0] press = 6'b101101;
    raw = 1'b0; edges(12);
    clr();
    for (int i = 5; i >= 0; i--) begin raw = press[i]; edges(1); end
    raw = 1'b1; edges(12);
    for (int i = 5; i >= 0; i--) begin raw = ~press[i]; edges(1); end
    raw = 1'b0; edges(12);
    ncmp++; if (ndet !== 2) begin nerr++; $display("FAIL chain_det: got %0d want 2", ndet); end
    ncmp++; if (nrise !== 1 || nfall !== 1) begin nerr++; $display("FAIL chain_pulses: rise %0d fall %0d want 1 1", nrise, nfall); end
    ncmp++; if (both !== 0) begin nerr++; $display("FAIL both_pulses: got %0d want 0", both); end
  endtask
  initial begin
    both = 0;
    test_reset();
    test_clean_step();
    test_release();
    test_bounce();
    test_short_pulse();
    test_boundary();
    test_async_reset();
    test_reset_raw_high();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/debounce_fsm.md
DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: number of input synchronizer flops, legal range 2..4.
REQ-002 SHALL provide parameter DB_CYCLES, default 1_000_000: stable-cycle count required to accept a level change (10 ms at 100 MHz), legal minimum 2.
REQ-003 SHALL provide port i_clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-004 SHALL provide port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide port i_raw, input, 1 bit: raw asynchronous switch level.
REQ-006 SHALL provide port o_lvl, output, 1 bit: debounced level; feeds the downstream dual-edge detector's i_lvl.
REQ-007 SHALL provide port o_rise, output, 1 bit: one-cycle pulse on an accepted 0->1 change.
REQ-008 SHALL provide port o_fall, output, 1 bit: one-cycle pulse on an accepted 1->0 change.

Function
REQ-009 SHALL pass i_raw through a SYNC_STAGES-deep flop chain; the last stage output is s, and no other logic samples i_raw.
REQ-010 SHALL implement a four-state FSM with states ZERO, WAIT1, ONE and WAIT0, plus an up-counter cnt of width $clog2(DB_CYCLES).
REQ-011 In ZERO: s=1 -> WAIT1 with cnt cleared to 0; s=0 -> stay.
REQ-012 In WAIT1: s=0 -> ZERO (bounce rejected, no pulse); s=1 and cnt==DB_CYCLES-1 -> ONE; otherwise cnt increments.
REQ-013 In ONE: s=0 -> WAIT0 with cnt cleared to 0; s=1 -> stay.
REQ-014 In WAIT0: s=1 -> ONE (bounce rejected, no pulse); s=0 and cnt==DB_CYCLES-1 -> ZERO; otherwise cnt increments.
REQ-015 o_lvl SHALL be registered: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-016 o_rise SHALL be registered and high for exactly the first cycle in ONE after a WAIT1->ONE transition; o_fall is the same for WAIT0->ZERO.
REQ-017 o_rise and o_fall SHALL be asserted in the same cycle o_lvl changes, and SHALL never both be high in one cycle.
REQ-018 Latency SHALL be exactly SYNC_STAGES+DB_CYCLES+1 rising edges, counted from the first edge that samples i_raw at its new stable value to o_lvl changing.
REQ-019 Any glitch on s during a WAIT state SHALL restart qualification from the stable state, and cnt SHALL be cleared on the next entry to WAIT.
REQ-020 cnt SHALL never wrap; it is only compared to DB_CYCLES-1 while in WAIT1 or WAIT0.
REQ-021 Unreachable state encodings SHALL recover to ZERO on the next edge with all outputs 0.

Reset
REQ-022 i_rst_n=0 SHALL asynchronously force the synchronizer flops to 0, the state to ZERO, cnt to 0, and o_lvl, o_rise and o_fall to 0.
REQ-023 After i_rst_n deasserts with i_raw held at 1, the block SHALL qualify normally and issue one o_rise after the REQ-018 latency.
REQ-024 Reset asserted mid-WAIT SHALL abandon the qualification with no pulse issued.

Verification (SYNC_STAGES=2, DB_CYCLES=4)
REQ-025 Clean step: i_raw goes 0->1 and is held -> o_lvl rises 7 edges later, o_rise high for 1 cycle, o_fall stays 0.
REQ-026 Bounce reject: i_raw goes 1 for 3 cycles, 0 for 2 cycles, then holds 1 -> exactly one o_rise, 7 edges after the final rising transition.
REQ-027 Short pulse: i_raw is high for 3 cycles only -> o_lvl stays 0, and no pulses occur.
REQ-028 Release: from ONE, i_raw goes to 0 and is held -> o_lvl falls 7 edges later, o_fall high for 1 cycle.
REQ-029 Async reset: i_rst_n pulled low between clock edges while in WAIT1 -> all outputs 0 immediately; after release with i_raw=0 the block stays in ZERO.
REQ-030 Chain with the downstream dual-edge detector: a bouncy press then a bouncy release -> the detector emits exactly two edge pulses.
